// File: rtl/bist_seq_ctrl.sv
`default_nettype none
// ============================================================================
// bist_seq_ctrl : LFSR pattern source + MISR compactor BIST sequencer.
// Option BIST_ZERO_PATTERN_EN appends one all-zero pattern.   Rev 1.0
// ============================================================================
module bist_seq_ctrl #(
  parameter int unsigned          PI_W      = 9,
  parameter int unsigned          PO_W      = 2,
  parameter logic [PI_W-1:0]      LFSR_TAPS = 9'h110,
  parameter logic [PI_W-1:0]      LFSR_SEED = 9'h001,
  parameter int unsigned          SIG_W     = 16,
  parameter logic [SIG_W-1:0]     MISR_POLY = 16'hB400,
  parameter int unsigned          N_PAT     = 511,
  parameter int unsigned          SETTLE    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SIG_W-1:0]  exp_sig,
  input  logic [PO_W-1:0]   cut_out,
  output logic [PI_W-1:0]   cut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam logic [PI_W-1:0] SEED        = (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;
  localparam logic [15:0]     LAST_PAT    = 16'(N_PAT - 1);
  localparam logic [15:0]     LAST_SETTLE = 16'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_APPLY   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [PI_W-1:0]   lfsr;
  logic [SIG_W-1:0]  misr;
  logic [15:0]       pat_cnt;
  logic [15:0]       settle_cnt;
  logic [SIG_W-1:0]  misr_next;
  logic [PI_W-1:0]   lfsr_next;

  always_comb begin
    misr_next = {misr[SIG_W-2:0], 1'b0}
              ^ (misr[SIG_W-1] ? MISR_POLY : '0)
              ^ SIG_W'(cut_out);
    lfsr_next = {lfsr[PI_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

`ifdef BIST_ZERO_PATTERN_EN
  logic zero_phase;
  assign cut_in = (busy && !zero_phase) ? lfsr : '0;
`else
  assign cut_in = busy ? lfsr : '0;
`endif

  assign signature = misr;

  // DONE is entered on the last capture edge with busy still set; the
  // following edge is the finalize step that compares the settled misr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED;
      misr       <= '0;
      pat_cnt    <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
`ifdef BIST_ZERO_PATTERN_EN
      zero_phase <= 1'b0;
`endif
    end else if (abort && busy) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
`ifdef BIST_ZERO_PATTERN_EN
      zero_phase <= 1'b0;
`endif
    end else if (start && !busy && !abort) begin
      state      <= S_APPLY;
      lfsr       <= SEED;
      misr       <= '0;
      pat_cnt    <= '0;
      settle_cnt <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
`ifdef BIST_ZERO_PATTERN_EN
      zero_phase <= 1'b0;
`endif
    end else begin
      case (state)
        S_APPLY: begin
          if (settle_cnt == LAST_SETTLE) begin
            settle_cnt <= '0;
            state      <= S_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        S_CAPTURE: begin
          misr <= misr_next;
          lfsr <= lfsr_next;
`ifdef BIST_ZERO_PATTERN_EN
          if (zero_phase) begin
            state <= S_DONE;
          end else begin
            pat_cnt <= pat_cnt + 16'd1;
            if (pat_cnt == LAST_PAT) zero_phase <= 1'b1;
            state <= S_APPLY;
          end
`else
          pat_cnt <= pat_cnt + 16'd1;
          state   <= (pat_cnt == LAST_PAT) ? S_DONE : S_APPLY;
`endif
        end
        S_DONE: begin
          if (busy) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (misr == exp_sig);
`ifdef BIST_ZERO_PATTERN_EN
            zero_phase <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bist_seq_ctrl.sv
`default_nettype none
// tb_bist_seq_ctrl : randomized self-checking bench; three instances with
// N_PAT = 511, 2 and 3, checked against a pattern-stream reference model.
module tb_bist_seq_ctrl;

`ifdef BIST_ZERO_PATTERN_EN
  localparam int ZEXT = 1;
`else
  localparam int ZEXT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = '0;
  logic [2:0]  abort = '0;
  logic [15:0] exp_sig [3];
  logic [1:0]  cut_out [3];
  logic [8:0]  cut_in  [3];
  logic [2:0]  busy, done, pass;
  logic [15:0] sig [3];
  logic [17:0] mask [3];
  logic [2:0]  force_en = 3'b111;
  logic [1:0]  force_val [3];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Stand-in cone: each output is the parity of a masked input subset.
  function automatic logic [1:0] cone(input logic [8:0] x, input logic [17:0] m);
    return {^(x & m[17:9]), ^(x & m[8:0])};
  endfunction

  assign cut_out[0] = force_en[0] ? force_val[0] : cone(cut_in[0], mask[0]);
  assign cut_out[1] = force_en[1] ? force_val[1] : cone(cut_in[1], mask[1]);
  assign cut_out[2] = force_en[2] ? force_val[2] : cone(cut_in[2], mask[2]);

  bist_seq_ctrl u_def (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .exp_sig(exp_sig[0]),
    .cut_out(cut_out[0]), .cut_in(cut_in[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .signature(sig[0]));
  bist_seq_ctrl #(.N_PAT(2)) u_n2 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .exp_sig(exp_sig[1]),
    .cut_out(cut_out[1]), .cut_in(cut_in[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .signature(sig[1]));
  bist_seq_ctrl #(.N_PAT(3)) u_n3 (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .exp_sig(exp_sig[2]),
    .cut_out(cut_out[2]), .cut_in(cut_in[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .signature(sig[2]));

  // ---------------- reference model ----------------
  function automatic int npat(input int idx);
    return (idx == 0) ? 511 : (idx == 1) ? 2 : 3;
  endfunction

  function automatic int exp_lat(input int idx);
    return 1 + (npat(idx) + ZEXT) * 2;
  endfunction

  // x^9 + x^5 + 1 Fibonacci step: feedback = bit8 xor bit4
  function automatic logic [8:0] lfsr_step(input logic [8:0] l);
    return {l[7:0], l[8] ^ l[4]};
  endfunction

  function automatic logic [8:0] pattern(input int n, input int p);
    logic [8:0] l = 9'h001;
    if (p >= n) return 9'h000;
    for (int i = 0; i < p; i++) l = lfsr_step(l);
    return l;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] o);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'hB400 : 16'h0000) ^ {14'b0, o};
  endfunction

  function automatic logic [15:0] model_sig(input int n, input int z, input logic [17:0] m,
                                           input logic fe, input logic [1:0] fv);
    logic [15:0] s = '0;
    for (int p = 0; p < n + z; p++) begin
      logic [8:0] x = pattern(n, p);
      s = misr_step(s, fe ? fv : cone(x, m));
    end
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic launch(input int idx);
    start[idx] = 1'b1; tick(); start[idx] = 1'b0;
  endtask

  task automatic cancel(input int idx);
    abort[idx] = 1'b1; tick(); abort[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int limit, output int cyc);
    cyc = 0;
    while (done[idx] !== 1'b1 && cyc < limit) begin tick(); cyc++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      vectors++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
      vectors++; if (done[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", i, done[i]); end
      vectors++; if (pass[i] !== 1'b0) begin errors++; $display("FAIL reset_pass[%0d]: got %b want 0", i, pass[i]); end
      vectors++; if (cut_in[i] !== 9'h000) begin errors++; $display("FAIL reset_cut_in[%0d]: got %h want 000", i, cut_in[i]); end
      vectors++; if (sig[i] !== 16'h0000) begin errors++; $display("FAIL reset_sig[%0d]: got %h want 0000", i, sig[i]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sequence();
    logic [8:0] seq [6] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
    force_en[0] = 1'b1; force_val[0] = 2'b00;
    launch(0);
    for (int p = 0; p < 6; p++) begin
      for (int h = 0; h < 2; h++) begin
        vectors++;
        if (cut_in[0] !== seq[p]) begin
          errors++; $display("FAIL seq_cut_in p%0d h%0d: got %h want %h", p, h, cut_in[0], seq[p]);
        end
        tick();
      end
    end
    cancel(0);
  endtask

  task automatic test_small_sig();
    logic [15:0] golden = model_sig(2, ZEXT, '0, 1'b1, 2'b11);
    int cyc;
    force_en[1] = 1'b1; force_val[1] = 2'b11;
    exp_sig[1] = golden;
    launch(1);
    tick(); tick();
    vectors++; if (sig[1] !== 16'h0003) begin errors++; $display("FAIL n2_first_capture: got %h want 0003", sig[1]); end
    wait_done(1, exp_lat(1) + 20, cyc);
`ifndef BIST_ZERO_PATTERN_EN
    vectors++; if (sig[1] !== 16'h0005) begin errors++; $display("FAIL n2_final_literal: got %h want 0005", sig[1]); end
`endif
    vectors++; if (sig[1] !== golden) begin errors++; $display("FAIL n2_final: got %h want %h", sig[1], golden); end
    vectors++; if (pass[1] !== 1'b1) begin errors++; $display("FAIL n2_pass_match: got %b want 1", pass[1]); end
    exp_sig[1] = golden ^ 16'h0003;
    launch(1);
    wait_done(1, exp_lat(1) + 20, cyc);
    vectors++; if (pass[1] !== 1'b0) begin errors++; $display("FAIL n2_pass_mismatch: got %b want 0", pass[1]); end
  endtask

  task automatic test_full_run();
    int cyc;
    force_en[0] = 1'b1; force_val[0] = 2'b00; exp_sig[0] = 16'h0000;
    launch(0);
    wait_done(0, exp_lat(0) + 50, cyc);
    vectors++; if (cyc !== exp_lat(0)) begin errors++; $display("FAIL full_latency: got %0d want %0d", cyc, exp_lat(0)); end
    vectors++; if (sig[0] !== 16'h0000) begin errors++; $display("FAIL full_sig: got %h want 0000", sig[0]); end
    vectors++; if (pass[0] !== 1'b1) begin errors++; $display("FAIL full_pass: got %b want 1", pass[0]); end
    vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL full_busy: got %b want 0", busy[0]); end
    repeat (7) tick();
    vectors++; if (done[0] !== 1'b1) begin errors++; $display("FAIL full_done_sticky: got %b want 1", done[0]); end
    launch(0);
    vectors++; if (done[0] !== 1'b0) begin errors++; $display("FAIL restart_done_clear: got %b want 0", done[0]); end
    vectors++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy[0]); end
    cancel(0);
  endtask

  task automatic test_abort();
    logic [17:0] m = 18'($urandom);
    logic [15:0] partial = model_sig(100, 0, m, 1'b0, 2'b00);
    mask[0] = m; force_en[0] = 1'b0;
    launch(0);
    repeat (200) tick();
    vectors++; if (cut_in[0] !== pattern(511, 100)) begin errors++; $display("FAIL abort_pat100: got %h want %h", cut_in[0], pattern(511, 100)); end
    cancel(0);
    vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy[0]); end
    vectors++; if (done[0] !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done[0]); end
    vectors++; if (pass[0] !== 1'b0) begin errors++; $display("FAIL abort_pass: got %b want 0", pass[0]); end
    vectors++; if (cut_in[0] !== 9'h000) begin errors++; $display("FAIL abort_cut_in: got %h want 000", cut_in[0]); end
    vectors++; if (sig[0] !== partial) begin errors++; $display("FAIL abort_sig_hold: got %h want %h", sig[0], partial); end
    launch(0);
    vectors++; if (cut_in[0] !== 9'h001) begin errors++; $display("FAIL abort_reseed: got %h want 001", cut_in[0]); end
    start[0] = 1'b1; abort[0] = 1'b1; tick(); start[0] = 1'b0; abort[0] = 1'b0;
    vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_beats_start: got %b want 0", busy[0]); end
    tick();
    vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b want 0", busy[0]); end
  endtask

  task automatic test_zero_pattern();
    logic [17:0] m = 18'($urandom);
    logic [15:0] golden = model_sig(3, ZEXT, m, 1'b0, 2'b00);
    int cyc;
    mask[2] = m; force_en[2] = 1'b0; exp_sig[2] = golden;
    launch(2);
    for (int p = 0; p < 3 + ZEXT; p++) begin
      for (int h = 0; h < 2; h++) begin
        vectors++;
        if (cut_in[2] !== pattern(3, p)) begin
          errors++; $display("FAIL n3_cut_in p%0d h%0d: got %h want %h", p, h, cut_in[2], pattern(3, p));
        end
        start[2] = (p == 1 && h == 0);
        tick();
        start[2] = 1'b0;
      end
    end
    vectors++; if (done[2] !== 1'b0) begin errors++; $display("FAIL n3_done_early: got %b want 0", done[2]); end
    wait_done(2, 20, cyc);
    vectors++; if (cyc !== 1) begin errors++; $display("FAIL n3_latency: got %0d want %0d", cyc + exp_lat(2) - 1, exp_lat(2)); end
    vectors++; if (sig[2] !== golden) begin errors++; $display("FAIL n3_sig: got %h want %h", sig[2], golden); end
    vectors++; if (pass[2] !== 1'b1) begin errors++; $display("FAIL n3_pass: got %b want 1", pass[2]); end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 8; it++) begin
      int idx = (it == 7) ? 0 : 1 + (it % 2);
      logic [17:0] m = 18'($urandom);
      bit good = 1'($urandom_range(0, 1));
      logic [15:0] golden = model_sig(npat(idx), ZEXT, m, 1'b0, 2'b00);
      int cyc;
      mask[idx] = m; force_en[idx] = 1'b0;
      exp_sig[idx] = good ? golden : golden ^ (16'h0001 << $urandom_range(0, 15));
      launch(idx);
      wait_done(idx, exp_lat(idx) + 20, cyc);
      vectors++; if (cyc !== exp_lat(idx)) begin errors++; $display("FAIL b2b_latency it%0d: got %0d want %0d", it, cyc, exp_lat(idx)); end
      vectors++; if (sig[idx] !== golden) begin errors++; $display("FAIL b2b_sig it%0d: got %h want %h", it, sig[idx], golden); end
      vectors++; if (pass[idx] !== good) begin errors++; $display("FAIL b2b_pass it%0d: got %b want %b", it, pass[idx], good); end
    end
  endtask

  task automatic test_reset_midrun();
    force_en[0] = 1'b0; mask[0] = 18'h2AD35;
    launch(0);
    repeat (21) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy[0]); end
    vectors++; if (cut_in[0] !== 9'h000) begin errors++; $display("FAIL midrst_cut_in: got %h want 000", cut_in[0]); end
    vectors++; if (sig[0] !== 16'h0000) begin errors++; $display("FAIL midrst_sig: got %h want 0000", sig[0]); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      exp_sig[i] = '0; mask[i] = '0; force_val[i] = '0;
    end
    test_reset();
    test_sequence();
    test_small_sig();
    test_full_run();
    test_abort();
    test_zero_pattern();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
